izh_param_loader: RTL and testbench
===================================

# izh_param_loader

Host-side parameter loader for the Izhikevich neuron tile: receives byte writes from the Tiny Tapeout pins over a 4-phase strobe/ack handshake, stages them in shadow registers and atomically commits them to the neuron core at a step boundary. It is the receiving end of the pin-level write protocol the bench/host drives, and sits between the top-level `ui_in`/`uio_in` pins and the neuron datapath.

## Interface
- No parameters; all widths fixed at 8 bits.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: tile enable; when low, no new write is accepted (in-flight handshake still completes).
- `wr_data` in 8: write data (from `ui_in`).
- `addr` in 3: register address (from `uio_in[2:0]`).
- `strb` in 1: write/read strobe (from `uio_in[3]`), asynchronous to `clk`.
- `rd` in 1: 1 = read, 0 = write (from `uio_in[4]`).
- `step_done` in 1: one-cycle pulse from neuron core at end of each integration step.
- `ack` out 1: handshake acknowledge (to `uio_out[5]`).
- `rd_data` out 8: readback byte (to `uo_out` when host reads).
- `p_a`, `p_b`, `p_c`, `p_d`, `p_i` out 8 each: active parameters to neuron core.
- `param_upd` out 1: one-cycle pulse when active parameters change.
- `commit_pend` out 1: commit armed, waiting for `step_done`.

## Operation
- Register map: 0 a (unsigned Q0.8), 1 b (unsigned Q0.8), 2 c (signed mV), 3 d (unsigned), 4 I (signed), 5 status (RO), 6 reserved (writes ignored, reads 0x00), 7 commit key (WO).
- Reset values (shadow and active): a=0x05, b=0x33, c=0xBF (-65), d=0x08, I=0x00; `ack`=0, `rd_data`=0x00, `param_upd`=0, `commit_pend`=0, err=0.
- `strb` passes a 2-flop synchronizer; rising edge of synchronized strobe with `ena`=1 starts a transaction; `wr_data`/`addr`/`rd` sampled in that edge-detect cycle (host holds them stable while `strb` high).
- FSM: IDLE -> (sync rising edge, ena) CAPTURE -> ACK (ack=1) -> (sync `strb`=0) IDLE. Rising edges while in ACK are impossible by protocol; any new edge only recognized from IDLE.
- Write addr 0-4: store to shadow register. If `commit_pend`=1, write is acked but dropped and err set.
- Write addr 7, data 0xA5: set `commit_pend`. Any other data: ignored, err set. Writing 0xA5 while already pending: no effect.
- Commit: in a cycle with `commit_pend`=1 and `step_done`=1, copy all five shadows to active, pulse `param_upd`, clear `commit_pend`.
- Status byte: {commit_pend, err, 6'b0}. err is sticky; cleared by reading status.
- Reads: `rd_data` loaded in CAPTURE with the addressed shadow register (status for 5, 0x00 for 6/7); held until next read.

## Timing
- Write latency: `strb` rise at pin -> shadow updated and `ack`=1 at end of 3rd `clk` edge (2 sync + 1 capture); `ack` asserted from cycle 4.
- `ack` drops 2 cycles after `strb` falls (sync delay) +1 state cycle.
- `commit_pend` high the cycle after key capture; if `step_done` coincides with key capture, commit occurs on the next `step_done`, not the same cycle.
- `param_upd` high exactly one cycle, same cycle active outputs change.
- Reset mid-handshake: FSM to IDLE, `ack`=0, all registers to defaults; a `strb` already high at reset release is not treated as a new edge (synchronizer resets to 0 but edge detect requires observed low first).

## Configuration
- `IZH_PARAM_READBACK_EN`: defined -> read transactions load `rd_data` as above and reading status clears err. Undefined -> `rd_data` tied 0x00, reads still acked, err cleared only by reset.

## Test plan
- Reset -> p_a=0x05, p_b=0x33, p_c=0xBF, p_d=0x08, p_i=0x00, ack=0, param_upd=0.
- Write 0x0A to addr 4, key 0xA5 to addr 7, pulse step_done -> p_i=0x0A after commit, param_upd single pulse; p_i unchanged before step_done.
- Write key 0x11 to addr 7 -> no commit_pend; read status -> 0x40; reread -> 0x00.
- Arm commit, then write 0x7F to addr 0 -> acked, dropped; after commit p_a=0x05, status=0xC0 before step_done... then 0x40 after.
- Read addr 2 after writing 0x9C -> rd_data=0x9C; with IZH_PARAM_READBACK_EN undefined -> 0x00.
- Assert rst_n=0 while ack=1 and strb held high -> ack=0, defaults restored, no write on release until strb toggles.

Source files
------------

// File: rtl/izh_param_loader.sv
`timescale 1ns/1ps
// izh_param_loader: strobe/ack byte-write port into shadow parameter registers, committed
// atomically to the neuron core on step_done. Optional readback path: IZH_PARAM_READBACK_EN.
module izh_param_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] wr_data,
    input  logic [2:0] addr,
    input  logic       strb,
    input  logic       rd,
    input  logic       step_done,
    output logic       ack,
    output logic [7:0] rd_data,
    output logic [7:0] p_a,
    output logic [7:0] p_b,
    output logic [7:0] p_c,
    output logic [7:0] p_d,
    output logic [7:0] p_i,
    output logic       param_upd,
    output logic       commit_pend
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    localparam logic [7:0] RST_A      = 8'h05;
    localparam logic [7:0] RST_B      = 8'h33;
    localparam logic [7:0] RST_C      = 8'hBF;
    localparam logic [7:0] RST_D      = 8'h08;
    localparam logic [7:0] RST_I      = 8'h00;
    localparam logic [7:0] COMMIT_KEY = 8'hA5;
    localparam logic [2:0] ADDR_LAST  = 3'd4;
    localparam logic [2:0] ADDR_STAT  = 3'd5;
    localparam logic [2:0] ADDR_KEY   = 3'd7;

    state_t     state;
    logic       strb_meta;
    logic       strb_sync;
    logic [1:0] fill;
    logic       seen_low;
    logic       err;
    logic [7:0] shadow [0:4];
    logic       take;

    // fill marks when strb_sync holds a real pin sample rather than its reset value, so a
    // strobe already high at reset release never looks like a fresh rising edge.
    assign take = (state == IDLE) && strb_sync && seen_low && ena;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            strb_meta   <= 1'b0;
            strb_sync   <= 1'b0;
            fill        <= 2'b00;
            seen_low    <= 1'b0;
            ack         <= 1'b0;
            err         <= 1'b0;
            commit_pend <= 1'b0;
            param_upd   <= 1'b0;
            // NOTE: the shadow array is reset because its defaults are architectural
            // (readable and committable); plain storage arrays normally stay unreset.
            shadow[0]   <= RST_A;
            shadow[1]   <= RST_B;
            shadow[2]   <= RST_C;
            shadow[3]   <= RST_D;
            shadow[4]   <= RST_I;
            p_a         <= RST_A;
            p_b         <= RST_B;
            p_c         <= RST_C;
            p_d         <= RST_D;
            p_i         <= RST_I;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every test below sees
            // the pre-edge value of commit_pend/err regardless of statement order.
            strb_meta <= strb;
            strb_sync <= strb_meta;
            fill      <= {fill[0], 1'b1};
            seen_low  <= fill[1] & ~strb_sync;
            param_upd <= 1'b0;

            if (commit_pend && step_done) begin
                p_a         <= shadow[0];
                p_b         <= shadow[1];
                p_c         <= shadow[2];
                p_d         <= shadow[3];
                p_i         <= shadow[4];
                param_upd   <= 1'b1;
                commit_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        state <= CAPTURE;
                        ack   <= 1'b1;
                        if (!rd) begin
                            if (addr <= ADDR_LAST) begin
                                if (commit_pend) err <= 1'b1;
                                else             shadow[addr] <= wr_data;
                            end else if (addr == ADDR_KEY) begin
                                if (wr_data != COMMIT_KEY) err <= 1'b1;
                                else if (!commit_pend)     commit_pend <= 1'b1;
                            end
                        end
`ifdef IZH_PARAM_READBACK_EN
                        else if (addr == ADDR_STAT) begin
                            err <= 1'b0;
                        end
`endif
                    end
                end
                CAPTURE: state <= ACK;
                ACK: begin
                    if (!strb_sync) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IZH_PARAM_READBACK_EN
    logic [7:0] rd_mux;

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        rd_mux = 8'h00;
        if (addr <= ADDR_LAST)       rd_mux = shadow[addr];
        else if (addr == ADDR_STAT)  rd_mux = {commit_pend, err, 6'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)          rd_data <= 8'h00;
        else if (take && rd) rd_data <= rd_mux;
    end
`else
    assign rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_izh_param_loader.sv
`timescale 1ns/1ps
// Self-checking bench for izh_param_loader: transaction-level model of the register file
// compared against the DUT every cycle, plus directed literal checks and random traffic.
module tb_izh_param_loader;

`ifdef IZH_PARAM_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic [2:0] addr = 3'd0;
    logic       strb = 1'b0;
    logic       rd = 1'b0;
    logic       step_done = 1'b0;
    logic       ack;
    logic [7:0] rd_data;
    logic [7:0] p_a, p_b, p_c, p_d, p_i;
    logic       param_upd;
    logic       commit_pend;

    izh_param_loader dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .addr(addr),
        .strb(strb), .rd(rd), .step_done(step_done), .ack(ack), .rd_data(rd_data),
        .p_a(p_a), .p_b(p_b), .p_c(p_c), .p_d(p_d), .p_i(p_i),
        .param_upd(param_upd), .commit_pend(commit_pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register file state as seen by the host and the core.
    logic [7:0] m_sh  [5];
    logic [7:0] m_act [5];
    bit         m_pend, m_err, m_upd, m_ack;
    logic [7:0] m_rd;
    bit         cmp_en  = 1'b0;
    bit         sd_auto = 1'b0;

    function automatic logic [7:0] def_val(input int i);
        case (i)
            0: return 8'h05;
            1: return 8'h33;
            2: return 8'hBF;
            3: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sh[i]  = def_val(i);
            m_act[i] = def_val(i);
        end
        m_pend = 0; m_err = 0; m_upd = 0; m_ack = 0; m_rd = 8'h00;
    endfunction

    // One clock edge of register-file behaviour; cap means a transaction is accepted here.
    function automatic void model_edge(input bit cap, input bit r, input logic [2:0] a,
                                       input logic [7:0] d, input bit sd);
        bit old_pend = m_pend;
        m_upd = 0;
        if (old_pend && sd) begin
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            m_upd  = 1;
            m_pend = 0;
        end
        if (cap) begin
            if (r) begin
                if (RB) begin
                    if (a <= 3'd4)      m_rd = m_sh[a];
                    else if (a == 3'd5) begin
                        m_rd  = {old_pend, m_err, 6'b0};
                        m_err = 0;
                    end else            m_rd = 8'h00;
                end
            end else if (a <= 3'd4) begin
                if (old_pend) m_err = 1;
                else          m_sh[a] = d;
            end else if (a == 3'd7) begin
                if (d != 8'hA5)    m_err = 1;
                else if (!old_pend) m_pend = 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en)
            check("outputs", {ack, rd_data, p_a, p_b, p_c, p_d, p_i, param_upd, commit_pend},
                  {m_ack, m_rd, m_act[0], m_act[1], m_act[2], m_act[3], m_act[4], m_upd, m_pend});
    end

    // Advance one clock; the model sees the same inputs the DUT sampled at that edge.
    task automatic tick(input bit cap, input bit ack_next);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(cap && ena, rd, addr, wr_data, step_done);
        m_ack = rst_n ? ack_next : 1'b0;
        #2;
        if (sd_auto) step_done = !step_done && ($urandom_range(0, 3) == 0);
    endtask

    // Full 4-phase handshake: capture on the 3rd edge after strb rises, ack drops on the
    // 3rd edge after strb falls.
    task automatic xact(input bit r, input logic [2:0] a, input logic [7:0] d,
                        input int hold, input bit sd_at_cap);
        bit acc = ena;
        rd = r; addr = a; wr_data = d; strb = 1'b1;
        tick(0, 0);
        tick(0, 0);
        if (sd_at_cap) step_done = 1'b1;
        tick(1, acc);
        if (sd_at_cap) step_done = 1'b0;
        repeat (hold) tick(0, acc);
        strb = 1'b0;
        tick(0, acc);
        tick(0, acc);
        tick(0, 0);
        wr_data = 8'($urandom);
        addr    = 3'($urandom);
        rd      = 1'($urandom);
    endtask

    task automatic pulse_step();
        step_done = 1'b1;
        tick(0, 0);
        step_done = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        tick(0, 0);
        cmp_en = 1'b1;
        tick(0, 0);
        rst_n = 1'b1;
        repeat (3) tick(0, 0);

        check("rst_p_a", p_a, 8'h05);
        check("rst_p_b", p_b, 8'h33);
        check("rst_p_c", p_c, 8'hBF);
        check("rst_p_d", p_d, 8'h08);
        check("rst_p_i", p_i, 8'h00);
        check("rst_ack", ack, 1'b0);
        check("rst_param_upd", param_upd, 1'b0);

        // Stage I, arm, commit.
        xact(0, 3'd4, 8'h0A, 1, 0);
        check("p_i_before_arm", p_i, 8'h00);
        xact(0, 3'd7, 8'hA5, 0, 0);
        check("pend_after_key", commit_pend, 1'b1);
        repeat (3) tick(0, 0);
        check("p_i_before_step", p_i, 8'h00);
        pulse_step();
        check("p_i_after_commit", p_i, 8'h0A);
        check("upd_pulse", param_upd, 1'b1);
        check("pend_cleared", commit_pend, 1'b0);
        tick(0, 0);
        check("upd_single", param_upd, 1'b0);

        // Bad key sets err, status read clears it.
        xact(0, 3'd7, 8'h11, 0, 0);
        check("bad_key_no_pend", commit_pend, 1'b0);
        xact(1, 3'd5, 8'h00, 0, 0);
        check("status_err", rd_data, RB ? 8'h40 : 8'h00);
        xact(1, 3'd5, 8'h00, 0, 0);
        check("status_reread", rd_data, 8'h00);

        // Write while pending is dropped.
        xact(0, 3'd7, 8'hA5, 0, 0);
        xact(0, 3'd0, 8'h7F, 2, 0);
        check("drop_pend", commit_pend, 1'b1);
        pulse_step();
        check("drop_p_a", p_a, 8'h05);
        xact(1, 3'd5, 8'h00, 0, 0);
        check("status_after_drop", rd_data, RB ? 8'h40 : 8'h00);

        // Key capture coinciding with step_done: commit waits for the next step_done.
        xact(0, 3'd1, 8'h44, 0, 0);
        xact(0, 3'd7, 8'hA5, 0, 1);
        check("coincide_pend", commit_pend, 1'b1);
        check("coincide_p_b", p_b, 8'h33);
        pulse_step();
        check("coincide_commit", p_b, 8'h44);

        // Readback of c.
        xact(0, 3'd2, 8'h9C, 0, 0);
        xact(1, 3'd2, 8'h00, 1, 0);
        check("read_c", rd_data, RB ? 8'h9C : 8'h00);

        // Disabled tile ignores the transaction.
        ena = 1'b0;
        xact(0, 3'd3, 8'h44, 1, 0);
        ena = 1'b1;
        xact(1, 3'd3, 8'h00, 0, 0);
        check("ena_ignored", rd_data, RB ? 8'h08 : 8'h00);

        // Reset while acked with strb held high.
        rd = 1'b0; addr = 3'd1; wr_data = 8'h77; strb = 1'b1;
        tick(0, 0); tick(0, 0); tick(1, 1);
        check("pre_reset_ack", ack, 1'b1);
        rst_n = 1'b0;
        tick(0, 0); tick(0, 0);
        check("reset_ack", ack, 1'b0);
        rst_n = 1'b1;
        repeat (6) tick(0, 0);
        check("no_edge_after_reset", ack, 1'b0);
        strb = 1'b0;
        repeat (3) tick(0, 0);
        xact(1, 3'd1, 8'h00, 0, 0);
        check("b_default_after_reset", rd_data, RB ? 8'h33 : 8'h00);

        // Random traffic against the model.
        sd_auto = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [2:0] a = 3'($urandom);
            logic [7:0] d = 8'($urandom);
            if (a == 3'd7 && $urandom_range(0, 1) == 1) d = 8'hA5;
            ena = ($urandom_range(0, 7) != 0);
            xact($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 2), 0);
            repeat ($urandom_range(0, 3)) tick(0, 0);
        end
        sd_auto = 1'b0;
        step_done = 1'b0;
        ena = 1'b1;
        repeat (2) tick(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
